// File: rtl/spi_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ctrl -- byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//
// Bridges a CPU register interface (tx byte + start strobe, rx byte + busy)
// to an external SPI slave such as an SD card. The SCK half-period is either
// one clk (fast, SCK = clk/2) or SLOW_HALF clks (slow, for SD-card init).
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst       synchronous active-high reset, aborts any transfer
//   txdata    byte to send, sampled on the start cycle
//   txstart   single-cycle start strobe, ignored while busy
//   rxdata    last fully received byte, only updated at end of transfer
//   busy      high while a transfer is in progress
//   slow      SCK speed select, sampled on the start cycle
//   spi_sck   SPI clock, idles low
//   spi_mosi  SPI data out, idles high
//   spi_miso  SPI data in, sampled on rising SCK
// -----------------------------------------------------------------------------
module spi_ctrl #(
    parameter int SLOW_HALF = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txdata,
    input  logic       txstart,
    output logic [7:0] rxdata,
    output logic       busy,
    input  logic       slow,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int DIV_W = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state_r;
    logic [7:0]         tx_sr_r;
    logic [7:0]         rx_sr_r;
    logic [DIV_W-1:0]   div_r;
    logic [3:0]         half_r;     // index of the current SCK half-period, 0..15
    logic               slow_r;     // speed latched at start, immune to later changes
    logic [DIV_W-1:0]   div_lim_s;
    logic               half_end_s;

    // Divider terminal count for the latched speed mode.
    always_comb begin
        div_lim_s = {DIV_W{1'b0}};
        if (slow_r) begin
            div_lim_s = DIV_W'(SLOW_HALF - 1);
        end else begin
            div_lim_s = {DIV_W{1'b0}};
        end
    end

    assign half_end_s = (div_r == div_lim_s);

    // Transfer sequencer: divider, half-period count, shift registers, outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            tx_sr_r  <= 8'h00;
            rx_sr_r  <= 8'h00;
            div_r    <= {DIV_W{1'b0}};
            half_r   <= 4'd0;
            slow_r   <= 1'b0;
            rxdata   <= 8'h00;
            busy     <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (txstart) begin
                        tx_sr_r  <= txdata;
                        rx_sr_r  <= 8'h00;
                        slow_r   <= slow;
                        div_r    <= {DIV_W{1'b0}};
                        half_r   <= 4'd0;
                        busy     <= 1'b1;
                        spi_sck  <= 1'b0;
                        spi_mosi <= txdata[7];
                        state_r  <= XFER;
                    end else begin
                        busy     <= 1'b0;
                        spi_sck  <= 1'b0;
                        spi_mosi <= 1'b1;
                    end
                end
                XFER: begin
                    if (half_end_s) begin
                        div_r  <= {DIV_W{1'b0}};
                        half_r <= half_r + 4'd1;
                        // Even-indexed half-periods end with a rising SCK edge.
                        if (!half_r[0]) begin
                            spi_sck <= 1'b1;
                            rx_sr_r <= {rx_sr_r[6:0], spi_miso};
                        end else begin
                            spi_sck <= 1'b0;
                            if (half_r == 4'd15) begin
                                rxdata   <= rx_sr_r;
                                busy     <= 1'b0;
                                spi_mosi <= 1'b1;
                                state_r  <= IDLE;
                            end else begin
                                tx_sr_r  <= {tx_sr_r[6:0], 1'b0};
                                spi_mosi <= tx_sr_r[6];
                            end
                        end
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                    spi_sck  <= 1'b0;
                    spi_mosi <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_ctrl -- self-checking bench for spi_ctrl.
// Each transfer is checked sample by sample against the timing rules:
// with half-period H, sample n after the start edge must show
// sck = (n/H) odd, mosi = tx bit 7-n/(2H), busy for exactly 16*H samples,
// and rxdata = byte presented on miso (or tx byte in loopback).
// -----------------------------------------------------------------------------
module tb_spi_ctrl;

    localparam int SH = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] txdata;
    logic       txstart;
    logic [7:0] rxdata;
    logic       busy;
    logic       slow;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       miso_drv;
    logic       loop_en;

    int tests = 0;
    int fails = 0;
    logic [7:0] last_rx;

    assign spi_miso = loop_en ? spi_mosi : miso_drv;

    spi_ctrl #(.SLOW_HALF(SH)) dut (
        .clk      (clk),
        .rst      (rst),
        .txdata   (txdata),
        .txstart  (txstart),
        .rxdata   (rxdata),
        .busy     (busy),
        .slow     (slow),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the first negedge with busy low.
    task automatic run_xfer(input string tag, input logic [7:0] tx, input logic sl,
                            input logic [7:0] mb, input logic lp, input logic disturb,
                            input logic [7:0] prev_rx);
        int h;
        int n;
        int b;
        int bad_sck;
        int bad_mosi;
        int bad_rx;
        logic exp_sck;
        logic [7:0] exp_rx;
        h = sl ? SH : 1;
        n = 0;
        bad_sck = 0;
        bad_mosi = 0;
        bad_rx = 0;
        exp_rx = lp ? tx : mb;
        loop_en  = lp;
        txdata   = tx;
        slow     = sl;
        miso_drv = mb[7];
        txstart  = 1'b1;
        @(negedge clk);
        txstart = 1'b0;
        txdata  = 8'($urandom);
        slow    = 1'($urandom);
        while (busy === 1'b1 && n < 16 * h) begin
            b = 7 - n / (2 * h);
            exp_sck = ((n / h) % 2) == 1;
            if (spi_sck !== exp_sck) bad_sck++;
            if (spi_mosi !== tx[b]) bad_mosi++;
            if (rxdata !== prev_rx) bad_rx++;
            miso_drv = mb[b];
            if (disturb && n == 3) begin
                txstart = 1'b1;
                txdata  = 8'hFF;
                slow    = ~sl;
            end else begin
                txstart = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        txstart = 1'b0;
        check({tag, "_busy_len"}, 32'(n), 32'(16 * h));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_sck_idle"}, 32'(spi_sck), 32'd0);
        check({tag, "_mosi_idle"}, 32'(spi_mosi), 32'd1);
        check({tag, "_sck_shape"}, 32'(bad_sck), 32'd0);
        check({tag, "_mosi_bits"}, 32'(bad_mosi), 32'd0);
        check({tag, "_rx_hold"}, 32'(bad_rx), 32'd0);
        check({tag, "_rxdata"}, 32'(rxdata), 32'(exp_rx));
        loop_en = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        txstart  = 1'b0;
        txdata   = 8'h00;
        slow     = 1'b0;
        miso_drv = 1'b1;
        loop_en  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sck", 32'(spi_sck), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd1);
        check("rst_rxdata", 32'(rxdata), 32'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sck", 32'(spi_sck), 32'd0);
        check("idle_mosi", 32'(spi_mosi), 32'd1);

        // Fast and slow transfers of 0x55 with miso held high.
        run_xfer("fast55", 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00);
        repeat (5) @(negedge clk);
        check("hold_rxdata", 32'(rxdata), 32'hFF);
        check("hold_busy", 32'(busy), 32'd0);
        run_xfer("slow55", 8'h55, 1'b1, 8'hFF, 1'b0, 1'b0, 8'hFF);

        // Loopback, second start issued right after busy falls.
        run_xfer("loopA5", 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF);
        run_xfer("loop3C", 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5);

        // Start strobe, txdata and slow disturbed mid-transfer.
        run_xfer("dist_fast", 8'h96, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h3C);
        run_xfer("dist_slow", 8'h69, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h5A);
        last_rx = 8'hC3;

        // Random bytes and speeds.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] tx;
            logic [7:0] mb;
            logic       sl;
            tx = 8'($urandom);
            mb = 8'($urandom);
            sl = (i < 3) ? 1'($urandom) : 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_xfer("rand", tx, sl, mb, 1'b0, 1'b0, last_rx);
            last_rx = mb;
        end

        // Reset during half-period 5 of a slow transfer.
        txdata  = 8'hB7;
        slow    = 1'b1;
        txstart = 1'b1;
        @(negedge clk);
        txstart = 1'b0;
        repeat (4 * SH + 5) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_sck", 32'(spi_sck), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sck", 32'(spi_sck), 32'd0);
        check("abort_mosi", 32'(spi_mosi), 32'd1);
        check("abort_rxdata", 32'(rxdata), 32'h00);
        rst = 1'b0;
        @(negedge clk);
        run_xfer("post_rst", 8'hE1, 1'b0, 8'h1E, 1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
